// File: rtl/cointoss_pkg.sv
// Shared coin-toss definitions: symbol codes, decoder FSM encoding and the
// successor tables used by both the generator checkers and the decoder.
package cointoss_pkg;

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;
    localparam logic [2:0] S7 = 3'd7;

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } dec_state_t;

    // Index is the previous symbol; value is the symbol a toss of 1 (resp. 0) leads to.
    localparam logic [2:0] SUCC1 [8] = '{S1, S3, S3, S5, S5, S7, S7, S0};
    localparam logic [2:0] SUCC0 [8] = '{S2, S2, S4, S4, S6, S6, S0, S2};

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        logic [7:0] res;
        if (val == 8'hFF) begin
            res = val;
        end else begin
            res = val + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cointoss_decoder_if.sv
// Symbol input and recovered-word output bundle of the coin-toss decoder.
// err_cnt only exists when COINTOSS_DEC_STATS_EN is defined.
interface cointoss_decoder_if #(
    parameter int WORD_W = 8
);
    logic              in_valid;
    logic [2:0]        in_sym;
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;
    logic              locked;
    logic              err_pulse;
    logic              ovf;
`ifdef COINTOSS_DEC_STATS_EN
    logic [7:0]        err_cnt;

    modport master (
        output in_valid, in_sym, word_ready,
        input  word_valid, word_data, locked, err_pulse, ovf, err_cnt
    );
    modport slave (
        input  in_valid, in_sym, word_ready,
        output word_valid, word_data, locked, err_pulse, ovf, err_cnt
    );
`else
    modport master (
        output in_valid, in_sym, word_ready,
        input  word_valid, word_data, locked, err_pulse, ovf
    );
    modport slave (
        input  in_valid, in_sym, word_ready,
        output word_valid, word_data, locked, err_pulse, ovf
    );
`endif
endinterface

// File: rtl/cointoss_step_lut.sv
// Combinational transition classifier: is prev->sym a legal step, and which
// toss bit does it encode.
module cointoss_step_lut
    import cointoss_pkg::*;
(
    input  logic [2:0] prev,
    input  logic [2:0] sym,
    output logic       legal,
    output logic       sym_bit
);

    // Look the pair up in both successor tables; the two entries never coincide.
    always_comb begin
        legal   = 1'b0;
        sym_bit = 1'b0;
        if (sym == SUCC1[prev]) begin
            legal   = 1'b1;
            sym_bit = 1'b1;
        end else if (sym == SUCC0[prev]) begin
            legal   = 1'b1;
            sym_bit = 1'b0;
        end else begin
            legal   = 1'b0;
            sym_bit = 1'b0;
        end
    end

endmodule

// File: rtl/cointoss_decoder.sv
// Coin-toss receive decoder: recovers toss bits from the symbol stream, packs
// them MSB-first into words and flags illegal steps. Build option: COINTOSS_DEC_STATS_EN.
module cointoss_decoder
    import cointoss_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic clk,
    input  logic rst,
    cointoss_decoder_if.slave bus
);

    localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    dec_state_t        state_r, state_s;
    logic [2:0]        prev_r, prev_s;
    logic [WORD_W-1:0] shreg_r, shreg_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              word_valid_r, word_valid_s;
    logic [WORD_W-1:0] word_data_r, word_data_s;
    logic              locked_r;
    logic              err_pulse_r, err_s;
    logic              ovf_r, ovf_s;
    logic              legal_s;
    logic              sym_bit_s;
    logic              complete_s;
    logic              slot_free_s;
    logic [WORD_W-1:0] shifted_s;

    cointoss_step_lut u_lut (
        .prev    (prev_r),
        .sym     (bus.in_sym),
        .legal   (legal_s),
        .sym_bit (sym_bit_s)
    );

    assign shifted_s   = {shreg_r[WORD_W-2:0], sym_bit_s};
    assign slot_free_s = !word_valid_r || bus.word_ready;

    // Next-state, packing and output-slot decisions.
    always_comb begin
        state_s      = state_r;
        prev_s       = prev_r;
        shreg_s      = shreg_r;
        cnt_s        = cnt_r;
        err_s        = 1'b0;
        complete_s   = 1'b0;
        ovf_s        = ovf_r;
        word_data_s  = word_data_r;
        word_valid_s = word_valid_r && !bus.word_ready;

        if (bus.in_valid) begin
            prev_s = bus.in_sym;
            case (state_r)
                HUNT: begin
                    state_s = TRACK;
                end
                TRACK: begin
                    if (legal_s) begin
                        shreg_s = shifted_s;
                        if (cnt_r == CNT_LAST) begin
                            cnt_s      = {CNT_W{1'b0}};
                            complete_s = 1'b1;
                        end else begin
                            cnt_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        err_s   = 1'b1;
                        shreg_s = {WORD_W{1'b0}};
                        cnt_s   = {CNT_W{1'b0}};
                    end
                end
                default: begin
                    state_s = HUNT;
                end
            endcase
        end else begin
            prev_s = prev_r;
        end

        // A finished word only lands if the slot is empty or draining this cycle.
        if (complete_s) begin
            if (slot_free_s) begin
                word_valid_s = 1'b1;
                word_data_s  = shifted_s;
            end else begin
                ovf_s = 1'b1;
            end
        end else begin
            ovf_s = ovf_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r       <= S0;
            shreg_r      <= {WORD_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            word_valid_r <= 1'b0;
            word_data_r  <= {WORD_W{1'b0}};
            locked_r     <= 1'b0;
            err_pulse_r  <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            prev_r       <= prev_s;
            shreg_r      <= shreg_s;
            cnt_r        <= cnt_s;
            word_valid_r <= word_valid_s;
            word_data_r  <= word_data_s;
            locked_r     <= (state_s == TRACK);
            err_pulse_r  <= err_s;
            ovf_r        <= ovf_s;
        end
    end

    assign bus.word_valid = word_valid_r;
    assign bus.word_data  = word_data_r;
    assign bus.locked     = locked_r;
    assign bus.err_pulse  = err_pulse_r;
    assign bus.ovf        = ovf_r;

`ifdef COINTOSS_DEC_STATS_EN
    logic [7:0] err_cnt_r;

    // Saturating count of illegal transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r <= 8'd0;
        end else if (err_s) begin
            err_cnt_r <= sat_inc8(err_cnt_r);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign bus.err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_cointoss_decoder.sv
// Directed self-checking bench for cointoss_decoder (WORD_W=8); also exercises
// err_cnt when COINTOSS_DEC_STATS_EN is defined.
module tb_cointoss_decoder;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    cointoss_decoder_if #(.WORD_W(8)) dec_if ();

    cointoss_decoder #(.WORD_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dec_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one symbol for one clock; returns #1 after the sampling edge.
    task automatic send_sym(input logic [2:0] s);
        dec_if.in_valid = 1'b1;
        dec_if.in_sym   = s;
        @(posedge clk);
        #1;
        dec_if.in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [2:0] seq [];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        dec_if.in_valid   = 1'b0;
        dec_if.in_sym     = 3'd0;
        dec_if.word_ready = 1'b1;
        rst = 1'b1;
        #1;
        check_eq("rst_word_valid", {31'd0, dec_if.word_valid}, 32'd0);
        check_eq("rst_word_data", {24'd0, dec_if.word_data}, 32'd0);
        check_eq("rst_locked", {31'd0, dec_if.locked}, 32'd0);
        check_eq("rst_err_pulse", {31'd0, dec_if.err_pulse}, 32'd0);
        check_eq("rst_ovf", {31'd0, dec_if.ovf}, 32'd0);
`ifdef COINTOSS_DEC_STATS_EN
        check_eq("rst_err_cnt", {24'd0, dec_if.err_cnt}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All-zero word with ready high
        seq = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd2, 3'd4, 3'd6, 3'd0};
        for (int i = 0; i < 9; i++) begin
            send_sym(seq[i]);
            check_eq($sformatf("z_err_%0d", i), {31'd0, dec_if.err_pulse}, 32'd0);
            check_eq($sformatf("z_valid_%0d", i), {31'd0, dec_if.word_valid}, (i == 8) ? 32'd1 : 32'd0);
            if (i == 0) check_eq("z_locked", {31'd0, dec_if.locked}, 32'd1);
        end
        check_eq("z_data", {24'd0, dec_if.word_data}, 32'h00);
        idle_cycle();
        check_eq("z_valid_drop", {31'd0, dec_if.word_valid}, 32'd0);

        // Alternating pattern 0xAB
        do_reset();
        seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        for (int i = 0; i < 9; i++) send_sym(seq[i]);
        check_eq("ab_valid", {31'd0, dec_if.word_valid}, 32'd1);
        check_eq("ab_data", {24'd0, dec_if.word_data}, 32'hAB);
        idle_cycle();

        // Repeated symbol mid-word, then counter restart -> 0xC0
        do_reset();
        send_sym(3'd0);
        send_sym(3'd1);
        check_eq("e_no_err", {31'd0, dec_if.err_pulse}, 32'd0);
        send_sym(3'd1);
        check_eq("e_err", {31'd0, dec_if.err_pulse}, 32'd1);
        check_eq("e_locked", {31'd0, dec_if.locked}, 32'd1);
`ifdef COINTOSS_DEC_STATS_EN
        check_eq("e_err_cnt", {24'd0, dec_if.err_cnt}, 32'd1);
`endif
        send_sym(3'd3);
        check_eq("e_err_clr", {31'd0, dec_if.err_pulse}, 32'd0);
        send_sym(3'd5);
        seq = '{3'd6, 3'd0, 3'd2, 3'd4, 3'd6, 3'd0};
        for (int i = 0; i < 6; i++) begin
            send_sym(seq[i]);
            check_eq($sformatf("e_valid_%0d", i), {31'd0, dec_if.word_valid}, (i == 5) ? 32'd1 : 32'd0);
        end
        check_eq("e_data", {24'd0, dec_if.word_data}, 32'hC0);
        idle_cycle();

        // Backpressure: second word dropped, ovf sticky
        do_reset();
        dec_if.word_ready = 1'b0;
        seq = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd1, 3'd3, 3'd5};
        for (int i = 0; i < 9; i++) send_sym(seq[i]);
        check_eq("bp_valid1", {31'd0, dec_if.word_valid}, 32'd1);
        check_eq("bp_data1", {24'd0, dec_if.word_data}, 32'hFF);
        check_eq("bp_ovf0", {31'd0, dec_if.ovf}, 32'd0);
        seq = '{3'd7, 3'd0, 3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd2};
        for (int i = 0; i < 8; i++) begin
            send_sym(seq[i]);
            if (i == 6) check_eq("bp_ovf_early", {31'd0, dec_if.ovf}, 32'd0);
        end
        check_eq("bp_ovf1", {31'd0, dec_if.ovf}, 32'd1);
        check_eq("bp_data_hold", {24'd0, dec_if.word_data}, 32'hFF);
        check_eq("bp_valid_hold", {31'd0, dec_if.word_valid}, 32'd1);
        dec_if.word_ready = 1'b1;
        idle_cycle();
        check_eq("bp_accept", {31'd0, dec_if.word_valid}, 32'd0);
        check_eq("bp_ovf_sticky", {31'd0, dec_if.ovf}, 32'd1);

        // Reset mid-word discards the partial word
        do_reset();
        check_eq("r_ovf_clr", {31'd0, dec_if.ovf}, 32'd0);
        seq = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd7};
        for (int i = 0; i < 5; i++) send_sym(seq[i]);
        rst = 1'b1;
        #1;
        check_eq("r_locked", {31'd0, dec_if.locked}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seq = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd2, 3'd4, 3'd6, 3'd0};
        for (int i = 0; i < 9; i++) begin
            send_sym(seq[i]);
            check_eq($sformatf("r_valid_%0d", i), {31'd0, dec_if.word_valid}, (i == 8) ? 32'd1 : 32'd0);
        end
        check_eq("r_data", {24'd0, dec_if.word_data}, 32'h00);
        idle_cycle();
        check_eq("r_one_word", {31'd0, dec_if.word_valid}, 32'd0);

`ifdef COINTOSS_DEC_STATS_EN
        // Saturation of the error counter
        do_reset();
        send_sym(3'd4);
        for (int i = 0; i < 300; i++) begin
            send_sym(3'd4);
            if (i == 2) check_eq("s_cnt3", {24'd0, dec_if.err_cnt}, 32'd3);
            if (i == 254) check_eq("s_cnt255", {24'd0, dec_if.err_cnt}, 32'd255);
        end
        check_eq("s_sat", {24'd0, dec_if.err_cnt}, 32'd255);
        check_eq("s_err_pulse", {31'd0, dec_if.err_pulse}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
